// File: rtl/msdap_pkg.sv
// ----------------------------------------------------------------------------
// msdap_pkg
// Shared definitions for the MSDAP datapath: the result word width, the
// serial bit period in sClk cycles, and the transmitter state encoding.
// Used by the FSM, the result path and the P2S transmitter.
// ----------------------------------------------------------------------------
package msdap_pkg;

    // Width of one filter result per channel.
    localparam int WORD_W       = 40;

    // sClk cycles per serial bit: 26.88 MHz / 768 kHz.
    localparam int CLKS_PER_BIT = 35;

    // Transmitter states.
    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } txState_t;

endpackage : msdap_pkg

// File: rtl/p2s_bit_timer.sv
// ----------------------------------------------------------------------------
// p2s_bit_timer
// Bit-period divider and bit counter for the P2S transmitter.
//
// Ports:
//   sClk    in   system clock (posedge)
//   clear   in   synchronous clear of both counters (reset or flush)
//   start   in   restart the counters at the first bit of a new word
//   run     in   counters advance only while a word is on the lines
//   bitCnt  out  index of the bit currently shifting, 0 = MSB
//   bitTick out  last sClk cycle of the current bit period
//   wordEnd out  last sClk cycle of the last bit of the word
// ----------------------------------------------------------------------------
module p2s_bit_timer
    import msdap_pkg::*;
#(
    parameter int NUM_BITS = WORD_W,
    parameter int DIV      = CLKS_PER_BIT,
    parameter int BIT_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1,
    parameter int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             sClk,
    input  logic             clear,
    input  logic             start,
    input  logic             run,
    output logic [BIT_W-1:0] bitCnt,
    output logic             bitTick,
    output logic             wordEnd
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);

    logic [DIV_W-1:0] divCnt;

    assign bitTick = run && (divCnt == DIV_LAST);
    assign wordEnd = bitTick && (bitCnt == BIT_LAST);

    always_ff @(posedge sClk) begin
        if (clear || start) begin
            divCnt <= '0;
            bitCnt <= '0;
        end else if (run) begin
            if (bitTick) begin
                // Both counters wrap to 0 at the end of a word, so a word
                // reloaded back-to-back starts with the counters already aligned.
                divCnt <= '0;
                bitCnt <= wordEnd ? '0 : bitCnt + BIT_W'(1);
            end else begin
                divCnt <= divCnt + DIV_W'(1);
            end
        end
    end

endmodule : p2s_bit_timer

// File: rtl/msdap_p2s_tx.sv
// ----------------------------------------------------------------------------
// msdap_p2s_tx
// Parallel-to-serial transmitter for the MSDAP result path. Takes a 40-bit
// left/right result pair on a one-cycle strobe and shifts both out MSB-first,
// one bit per CLKS_PER_BIT sClk cycles, with a frame pulse on the first bit.
// A one-word holding register absorbs a result that arrives mid-word; a
// further strobe while that register is full is dropped and flagged.
//
// Ports:
//   sClk      in   system clock (posedge)
//   reset     in   synchronous active-high reset, highest priority
//   flush     in   synchronous abort of current and pending words
//   outReady  in   one-cycle strobe, resultL/resultR valid
//   resultL   in   left-channel result  [WORD_W-1:0]
//   resultR   in   right-channel result [WORD_W-1:0]
//   frameOut  out  high for the first bit period of each word
//   serialL   out  left serial data
//   serialR   out  right serial data
//   txBusy    out  high while a word is shifting
//   overrun   out  one-cycle pulse when a strobe is dropped
//
// All outputs are registered from the internal state, so they trail the
// state by one cycle: a strobe sampled at edge k shows on the lines from
// edge k+1.
// ----------------------------------------------------------------------------
module msdap_p2s_tx
    import msdap_pkg::txState_t;
    import msdap_pkg::TX_IDLE;
    import msdap_pkg::TX_SHIFT;
#(
    parameter int WORD_W       = msdap_pkg::WORD_W,
    parameter int CLKS_PER_BIT = msdap_pkg::CLKS_PER_BIT
) (
    input  logic              sClk,
    input  logic              reset,
    input  logic              flush,
    input  logic              outReady,
    input  logic [WORD_W-1:0] resultL,
    input  logic [WORD_W-1:0] resultR,
    output logic              frameOut,
    output logic              serialL,
    output logic              serialR,
    output logic              txBusy,
    output logic              overrun
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    txState_t          state;
    logic [WORD_W-1:0] shL;
    logic [WORD_W-1:0] shR;
    logic [WORD_W-1:0] pendL;
    logic [WORD_W-1:0] pendR;
    logic              pendValid;
    logic              dropFlag;

    logic [BIT_W-1:0]  bitCnt;
    logic              bitTick;
    logic              wordEnd;
    logic              clearAll;
    logic              startIdle;
    logic              shifting;

    assign clearAll  = reset || flush;
    assign shifting  = (state == TX_SHIFT);
    assign startIdle = (state == TX_IDLE) && outReady;

    p2s_bit_timer #(
        .NUM_BITS (WORD_W),
        .DIV      (CLKS_PER_BIT),
        .BIT_W    (BIT_W)
    ) uBitTimer (
        .sClk    (sClk),
        .clear   (clearAll),
        .start   (startIdle),
        .run     (shifting),
        .bitCnt  (bitCnt),
        .bitTick (bitTick),
        .wordEnd (wordEnd)
    );

    always_ff @(posedge sClk) begin
        if (clearAll) begin
            // Reset and flush both discard every word in flight; any strobe
            // in the same cycle is ignored.
            state     <= TX_IDLE;
            shL       <= '0;
            shR       <= '0;
            pendL     <= '0;
            pendR     <= '0;
            pendValid <= 1'b0;
            dropFlag  <= 1'b0;
            frameOut  <= 1'b0;
            serialL   <= 1'b0;
            serialR   <= 1'b0;
            txBusy    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Output registers: one cycle behind the shifter/counter state.
            frameOut <= shifting && (bitCnt == '0);
            serialL  <= shifting && shL[WORD_W-1];
            serialR  <= shifting && shR[WORD_W-1];
            txBusy   <= shifting;
            overrun  <= dropFlag;
            dropFlag <= 1'b0;

            case (state)
                TX_IDLE: begin
                    if (outReady) begin
                        shL   <= resultL;
                        shR   <= resultR;
                        state <= TX_SHIFT;
                    end
                end

                TX_SHIFT: begin
                    if (wordEnd) begin
                        if (pendValid) begin
                            shL <= pendL;
                            shR <= pendR;
                            // A strobe coinciding with the pend handoff
                            // refills the holding register, so nothing drops.
                            if (outReady) begin
                                pendL <= resultL;
                                pendR <= resultR;
                            end else begin
                                pendValid <= 1'b0;
                            end
                        end else if (outReady) begin
                            shL <= resultL;
                            shR <= resultR;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        if (bitTick) begin
                            shL <= {shL[WORD_W-2:0], 1'b0};
                            shR <= {shR[WORD_W-2:0], 1'b0};
                        end
                        if (outReady) begin
                            if (!pendValid) begin
                                pendL     <= resultL;
                                pendR     <= resultR;
                                pendValid <= 1'b1;
                            end else begin
                                // Holding register keeps the older word.
                                dropFlag <= 1'b1;
                            end
                        end
                    end
                end

                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule : msdap_p2s_tx

// File: tb/tb_msdap_p2s_tx.sv
module tb_msdap_p2s_tx;

    localparam int W   = 40;
    localparam int CPB = 35;
    localparam int WORD_CLKS = W * CPB;

    logic         sClk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         outReady = 1'b0;
    logic [W-1:0] resultL = '0;
    logic [W-1:0] resultR = '0;
    logic         frameOut;
    logic         serialL;
    logic         serialR;
    logic         txBusy;
    logic         overrun;

    int nCmp = 0;
    int nErr = 0;

    msdap_p2s_tx #(
        .WORD_W       (W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .sClk     (sClk),
        .reset    (reset),
        .flush    (flush),
        .outReady (outReady),
        .resultL  (resultL),
        .resultR  (resultR),
        .frameOut (frameOut),
        .serialL  (serialL),
        .serialR  (serialR),
        .txBusy   (txBusy),
        .overrun  (overrun)
    );

    always #5 sClk = ~sClk;

    task automatic check(input string tag, input longint got, input longint exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sClk);
            #1;
        end
    endtask

    // Strobe sampled at the next edge; returns #1 after that edge (cycle 0).
    task automatic strobe(input logic [W-1:0] l, input logic [W-1:0] r);
        outReady = 1'b1;
        resultL  = l;
        resultR  = r;
        tick(1);
        outReady = 1'b0;
    endtask

    // Watches one word for cycles 1..1400 after its load edge, optionally
    // strobing new words at cycles s1/s2 (sampled at that cycle's edge).
    task automatic watchWord(input string tag,
                             input logic [W-1:0] wl, input logic [W-1:0] wr,
                             input int s1, input logic [W-1:0] s1L, input logic [W-1:0] s1R,
                             input int s2, input logic [W-1:0] s2L, input logic [W-1:0] s2R,
                             output int ovCnt, output int ovAt);
        int badL = 0;
        int badR = 0;
        int badF = 0;
        int badB = 0;
        int idx;
        ovCnt = 0;
        ovAt  = -1;
        for (int c = 1; c <= WORD_CLKS; c++) begin
            if (c == s1) begin
                outReady = 1'b1; resultL = s1L; resultR = s1R;
            end else if (c == s2) begin
                outReady = 1'b1; resultL = s2L; resultR = s2R;
            end else begin
                outReady = 1'b0;
            end
            tick(1);
            idx = W - 1 - (c - 1) / CPB;
            if (serialL !== wl[idx]) badL++;
            if (serialR !== wr[idx]) badR++;
            if (frameOut !== (c <= CPB)) badF++;
            if (txBusy !== 1'b1) badB++;
            if (overrun === 1'b1) begin
                ovCnt++;
                if (ovAt < 0) ovAt = c;
            end
        end
        outReady = 1'b0;
        check({tag, " serialL bad cycles"}, badL, 0);
        check({tag, " serialR bad cycles"}, badR, 0);
        check({tag, " frameOut bad cycles"}, badF, 0);
        check({tag, " txBusy bad cycles"}, badB, 0);
    endtask

    task automatic checkZero(input string tag);
        check({tag, " frameOut"}, frameOut, 0);
        check({tag, " serialL"}, serialL, 0);
        check({tag, " serialR"}, serialR, 0);
        check({tag, " txBusy"}, txBusy, 0);
        check({tag, " overrun"}, overrun, 0);
    endtask

    // Runs n quiet cycles and counts any frame or busy activity.
    task automatic quiet(input string tag, input int n);
        int fr = 0;
        int bz = 0;
        for (int c = 0; c < n; c++) begin
            tick(1);
            if (frameOut === 1'b1) fr++;
            if (txBusy === 1'b1) bz++;
        end
        check({tag, " frameOut cycles"}, fr, 0);
        check({tag, " txBusy cycles"}, bz, 0);
    endtask

    initial begin
        int ov;
        int ovAt;

        // Reset
        tick(3);
        checkZero("reset");
        reset = 1'b0;
        tick(2);
        checkZero("idle after reset");

        // T1: single word
        strobe(40'h80_0000_0001, 40'h00_0000_0000);
        watchWord("T1", 40'h80_0000_0001, 40'h00_0000_0000,
                  -1, '0, '0, -1, '0, '0, ov, ovAt);
        check("T1 overrun count", ov, 0);
        tick(1);
        check("T1 txBusy at 1401", txBusy, 0);
        check("T1 frameOut at 1401", frameOut, 0);
        check("T1 serialL at 1401", serialL, 0);

        // T2: second word pended at 500, goes out back-to-back
        tick(5);
        strobe(40'hAA_AAAA_AAAA, 40'h00_FFFF_0000);
        watchWord("T2w1", 40'hAA_AAAA_AAAA, 40'h00_FFFF_0000,
                  500, 40'h55_5555_5555, 40'h0F_0F0F_0F0F, -1, '0, '0, ov, ovAt);
        check("T2w1 overrun count", ov, 0);
        watchWord("T2w2", 40'h55_5555_5555, 40'h0F_0F0F_0F0F,
                  -1, '0, '0, -1, '0, '0, ov, ovAt);
        check("T2w2 overrun count", ov, 0);
        tick(1);
        check("T2 txBusy after", txBusy, 0);

        // T3: third strobe dropped
        tick(5);
        strobe(40'hC3_0000_00F1, 40'h81_2345_6789);
        watchWord("T3w1", 40'hC3_0000_00F1, 40'h81_2345_6789,
                  100, 40'h3C_FFFF_FF0E, 40'h7E_DCBA_9876,
                  200, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, ov, ovAt);
        check("T3 overrun count", ov, 1);
        check("T3 overrun cycle", ovAt, 201);
        watchWord("T3w2", 40'h3C_FFFF_FF0E, 40'h7E_DCBA_9876,
                  -1, '0, '0, -1, '0, '0, ov, ovAt);
        check("T3w2 overrun count", ov, 0);
        tick(1);
        check("T3 txBusy after", txBusy, 0);
        quiet("T3 dropped word absent", 100);

        // T4: strobe on the end-of-word cycle with pend empty
        strobe(40'h12_3456_789A, 40'h01_0000_0080);
        watchWord("T4w1", 40'h12_3456_789A, 40'h01_0000_0080,
                  WORD_CLKS, 40'hFE_DCBA_9876, 40'h80_0000_0001, -1, '0, '0, ov, ovAt);
        check("T4w1 overrun count", ov, 0);
        watchWord("T4w2", 40'hFE_DCBA_9876, 40'h80_0000_0001,
                  -1, '0, '0, -1, '0, '0, ov, ovAt);
        tick(1);
        check("T4 txBusy after", txBusy, 0);

        // T5: end of word with pend full and a strobe in the same cycle
        tick(3);
        strobe(40'hF0_0000_000F, 40'h00_0000_0000);
        watchWord("T5w1", 40'hF0_0000_000F, 40'h00_0000_0000,
                  100, 40'h0F_F000_0FF0, 40'h11_1111_1111,
                  WORD_CLKS, 40'hA5_A5A5_A5A5, 40'h5A_5A5A_5A5A, ov, ovAt);
        check("T5w1 overrun count", ov, 0);
        watchWord("T5w2", 40'h0F_F000_0FF0, 40'h11_1111_1111,
                  -1, '0, '0, -1, '0, '0, ov, ovAt);
        watchWord("T5w3", 40'hA5_A5A5_A5A5, 40'h5A_5A5A_5A5A,
                  -1, '0, '0, -1, '0, '0, ov, ovAt);
        tick(1);
        check("T5 txBusy after", txBusy, 0);

        // T6: flush at cycle 700 with a pending word
        tick(3);
        strobe(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF);
        for (int c = 1; c <= 700; c++) begin
            outReady = (c == 100);
            resultL  = 40'hFF_0000_FFFF;
            resultR  = 40'hFF_FFFF_0000;
            flush    = (c == 700);
            tick(1);
        end
        outReady = 1'b0;
        flush    = 1'b0;
        tick(1);
        checkZero("T6 after flush");
        quiet("T6 post-flush", WORD_CLKS + 100);

        // T7: reset mid-word together with a strobe
        strobe(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF);
        tick(299);
        reset    = 1'b1;
        outReady = 1'b1;
        resultL  = 40'h80_0000_0000;
        resultR  = 40'h80_0000_0000;
        tick(1);
        reset    = 1'b0;
        outReady = 1'b0;
        tick(1);
        checkZero("T7 after reset");
        quiet("T7 post-reset", WORD_CLKS + 100);
        strobe(40'h96_69C3_3C81, 40'h7F_FFFF_FFFE);
        watchWord("T7 fresh", 40'h96_69C3_3C81, 40'h7F_FFFF_FFFE,
                  -1, '0, '0, -1, '0, '0, ov, ovAt);
        tick(1);
        check("T7 txBusy after", txBusy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule : tb_msdap_p2s_tx
